// File: rtl/mem_arbiter_if.sv
// Bundle of client (I-cache, D-cache) and physical memory signals around mem_arbiter.
// master = arbiter view, slave = caches plus physical memory view.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) ();
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport master (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging I-cache and D-cache line transfers onto one memory port.
// Each grant is held until pmem_resp, followed by one dead cycle before re-arbitration.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  pmem_read_q, pmem_read_d;
    logic                  pmem_write_q, pmem_write_d;
    logic [ADDR_WIDTH-1:0] pmem_address_q, pmem_address_d;
    logic [LINE_WIDTH-1:0] pmem_wdata_q, pmem_wdata_d;
    logic                  d_req;
    logic                  pick_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= GRANT_I;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        d_req          = bus.d_read | bus.d_write;
        pick_d         = 1'b0;

        case (state_q)
            IDLE: begin
                // On a conflict the side opposite the previous grant wins.
                pick_d = d_req && (!bus.i_read || (last_grant_q == GRANT_I));
                if (pick_d) begin
                    state_d        = SERVE_D;
                    last_grant_d   = GRANT_D;
                    pmem_address_d = bus.d_address;
                    pmem_wdata_d   = bus.d_wdata;
                    pmem_write_d   = bus.d_write;
                    pmem_read_d    = !bus.d_write;
                end else if (bus.i_read) begin
                    state_d        = SERVE_I;
                    last_grant_d   = GRANT_I;
                    pmem_address_d = bus.i_address;
                    pmem_read_d    = 1'b1;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.pmem_resp) begin
                    state_d      = DONE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Completion and read data are steered only to the side currently being served.
    assign bus.i_resp       = (state_q == SERVE_I) && bus.pmem_resp;
    assign bus.d_resp       = (state_q == SERVE_D) && bus.pmem_resp;
    assign bus.i_rdata      = (state_q == SERVE_I) ? bus.pmem_rdata : '0;
    assign bus.d_rdata      = (state_q == SERVE_D) ? bus.pmem_rdata : '0;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_address_q;
    assign bus.pmem_wdata   = pmem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: single-side transfers, round-robin conflicts,
// input stability, stray/abandoned responses and asynchronous reset mid-transaction.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int LW = 128;
    localparam logic [LW-1:0] DEAD = 128'h0123_4567_89AB_CDEF_0011_2233_4455_DEAD;
    localparam logic [LW-1:0] A5   = {16{8'hA5}};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 2 units later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        bus.i_read     = 1'b0;
        bus.i_address  = '0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_address  = '0;
        bus.d_wdata    = '0;
        bus.pmem_resp  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        bus.pmem_rdata = 128'hBAD;
        rst_n = 1'b0;
        cyc();
        cyc();
        settle();
        check_eq("rst_pmem_read",  bus.pmem_read,    0);
        check_eq("rst_pmem_write", bus.pmem_write,   0);
        check_eq("rst_pmem_addr",  bus.pmem_address, 0);
        check_eq("rst_pmem_wdata", bus.pmem_wdata,   0);
        check_eq("rst_i_resp",     bus.i_resp,       0);
        check_eq("rst_d_resp",     bus.d_resp,       0);
        check_eq("rst_i_rdata",    bus.i_rdata,      0);
        check_eq("rst_d_rdata",    bus.d_rdata,      0);
        cyc();
        rst_n = 1'b1;

        // I-only read
        cyc();
        bus.i_read = 1'b1;
        bus.i_address = 16'h1230;
        settle();
        check_eq("t1_idle_read", bus.pmem_read, 0);
        cyc();
        settle();
        check_eq("t1_read",   bus.pmem_read,    1);
        check_eq("t1_addr",   bus.pmem_address, 16'h1230);
        check_eq("t1_i_resp_early", bus.i_resp, 0);
        cyc();
        cyc();
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = DEAD;
        settle();
        check_eq("t1_i_resp",  bus.i_resp,  1);
        check_eq("t1_i_rdata", bus.i_rdata, DEAD);
        check_eq("t1_d_resp",  bus.d_resp,  0);
        check_eq("t1_d_rdata", bus.d_rdata, 0);
        cyc();
        bus.pmem_resp = 1'b0;
        bus.i_read = 1'b0;
        settle();
        check_eq("t1_done_read",  bus.pmem_read, 0);
        check_eq("t1_done_iresp", bus.i_resp,    0);
        check_eq("t1_done_rdata", bus.i_rdata,   0);
        cyc();

        // D write-back with unstable inputs during SERVE_D
        bus.d_write = 1'b1;
        bus.d_address = 16'h8040;
        bus.d_wdata = A5;
        cyc();
        settle();
        check_eq("t2_write", bus.pmem_write,   1);
        check_eq("t2_read",  bus.pmem_read,    0);
        check_eq("t2_addr",  bus.pmem_address, 16'h8040);
        check_eq("t2_wdata", bus.pmem_wdata,   A5);
        bus.d_address = 16'hFFFE;
        bus.d_wdata = '0;
        cyc();
        settle();
        check_eq("t4_addr_hold",  bus.pmem_address, 16'h8040);
        check_eq("t4_wdata_hold", bus.pmem_wdata,   A5);
        check_eq("t4_write_hold", bus.pmem_write,   1);
        cyc();
        bus.pmem_resp = 1'b1;
        settle();
        check_eq("t2_d_resp", bus.d_resp,    1);
        check_eq("t2_i_resp", bus.i_resp,    0);
        check_eq("t2_read_resp", bus.pmem_read, 0);
        cyc();
        bus.pmem_resp = 1'b0;
        bus.d_write = 1'b0;
        settle();
        check_eq("t2_done_write", bus.pmem_write, 0);
        check_eq("t2_done_dresp", bus.d_resp,     0);
        cyc();

        // Stray pmem_resp in IDLE, then an abandoned I read
        bus.pmem_resp = 1'b1;
        settle();
        check_eq("t5_stray_i", bus.i_resp, 0);
        check_eq("t5_stray_d", bus.d_resp, 0);
        cyc();
        bus.pmem_resp = 1'b0;
        settle();
        check_eq("t5_stray_read", bus.pmem_read, 0);
        bus.i_read = 1'b1;
        bus.i_address = 16'h0440;
        cyc();
        bus.i_read = 1'b0;
        settle();
        check_eq("t5_ab_read", bus.pmem_read, 1);
        cyc();
        settle();
        check_eq("t5_ab_hold", bus.pmem_read, 1);
        cyc();
        bus.pmem_resp = 1'b1;
        settle();
        check_eq("t5_ab_iresp", bus.i_resp, 1);
        cyc();
        settle();
        check_eq("t5_done_iresp", bus.i_resp,    0);
        check_eq("t5_done_read",  bus.pmem_read, 0);
        cyc();
        bus.pmem_resp = 1'b0;

        // Round-robin conflict from reset: D, I, D
        do_reset();
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        bus.i_address = 16'h1000;
        bus.d_address = 16'h2000;
        settle();
        check_eq("t3_idle_read", bus.pmem_read, 0);
        cyc();
        settle();
        check_eq("t3_g1_addr",  bus.pmem_address, 16'h2000);
        check_eq("t3_g1_read",  bus.pmem_read,    1);
        check_eq("t3_g1_write", bus.pmem_write,   0);
        bus.pmem_resp = 1'b1;
        settle();
        check_eq("t3_g1_dresp", bus.d_resp, 1);
        check_eq("t3_g1_iresp", bus.i_resp, 0);
        cyc();
        bus.pmem_resp = 1'b0;
        settle();
        check_eq("t3_done1_read", bus.pmem_read, 0);
        cyc();
        settle();
        check_eq("t3_idle2_read", bus.pmem_read, 0);
        cyc();
        settle();
        check_eq("t3_g2_addr", bus.pmem_address, 16'h1000);
        check_eq("t3_g2_read", bus.pmem_read,    1);
        bus.pmem_resp = 1'b1;
        settle();
        check_eq("t3_g2_iresp", bus.i_resp, 1);
        check_eq("t3_g2_dresp", bus.d_resp, 0);
        cyc();
        bus.pmem_resp = 1'b0;
        cyc();
        cyc();
        settle();
        check_eq("t3_g3_addr", bus.pmem_address, 16'h2000);
        bus.pmem_resp = 1'b1;
        settle();
        check_eq("t3_g3_dresp", bus.d_resp, 1);
        check_eq("t3_g3_iresp", bus.i_resp, 0);
        cyc();
        idle_inputs();
        cyc();

        // Asynchronous reset during an outstanding write
        bus.d_write = 1'b1;
        bus.d_address = 16'h3000;
        bus.d_wdata = A5;
        cyc();
        settle();
        check_eq("t6_write", bus.pmem_write, 1);
        rst_n = 1'b0;
        bus.d_write = 1'b0;
        #1;
        check_eq("t6_async_write", bus.pmem_write,   0);
        check_eq("t6_async_addr",  bus.pmem_address, 0);
        cyc();
        rst_n = 1'b1;
        bus.pmem_resp = 1'b1;
        settle();
        check_eq("t6_late_dresp", bus.d_resp, 0);
        check_eq("t6_late_iresp", bus.i_resp, 0);
        cyc();
        bus.pmem_resp = 1'b0;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        bus.i_address = 16'h1000;
        bus.d_address = 16'h2000;
        cyc();
        settle();
        check_eq("t6_grant_addr", bus.pmem_address, 16'h2000);
        check_eq("t6_grant_read", bus.pmem_read,    1);
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the pipelined LC-3b datapath's split memory ports, behind its instruction cache (port a) and data cache (port b).
- Merges the two caches' line-fill and write-back requests onto the single physical memory port.
- Arbitrates between the two requesters and holds each granted transaction until physical memory responds.

Parameters:
- ADDR_WIDTH, 16, byte address width on all ports.
- LINE_WIDTH, 128, cache line width in bits on all data buses.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- i_read  input  1  instruction cache line-read request; held until i_resp.
- i_address  input  ADDR_WIDTH  instruction line address.
- i_rdata  output  LINE_WIDTH  line returned to instruction cache.
- i_resp  output  1  one-cycle completion pulse to instruction cache.
- d_read  input  1  data cache line-read request; held until d_resp.
- d_write  input  1  data cache line write-back request; held until d_resp.
- d_address  input  ADDR_WIDTH  data line address.
- d_wdata  input  LINE_WIDTH  write-back line.
- d_rdata  output  LINE_WIDTH  line returned to data cache.
- d_resp  output  1  one-cycle completion pulse to data cache.
- pmem_read  output  1  physical memory read command.
- pmem_write  output  1  physical memory write command.
- pmem_address  output  ADDR_WIDTH  registered physical address.
- pmem_wdata  output  LINE_WIDTH  registered write line.
- pmem_rdata  input  LINE_WIDTH  physical read line, valid with pmem_resp.
- pmem_resp  input  1  physical memory completion pulse.

Behaviour:
- Clock and reset: one clock, clk; reset is rst_n, asynchronous and active-low.
- Reset values: state=IDLE, last_grant=I. pmem_read, pmem_write, pmem_address, pmem_wdata, i_resp and d_resp all 0. i_rdata and d_rdata are 0 and mirror pmem_rdata only while granted.
- FSM states: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE, one side requesting: the single requester is granted.
- IDLE, both sides requesting: round-robin, granting the side opposite last_grant. The first conflict after reset therefore goes to D.
- On grant (IDLE edge): pmem_address latches the requester's address, last_grant updates, and the FSM moves to SERVE_x.
  - For D: pmem_wdata latches d_wdata.
  - For D, pmem_write is d_write; otherwise pmem_read=1.
  - d_read and d_write together is illegal; write wins.
- Command timing: pmem_read/pmem_write are registered and asserted from the first SERVE cycle until the cycle pmem_resp is seen. That is one cycle after the request first appears in IDLE.
- SERVE_x with pmem_resp=1:
  - x_resp=1 combinationally in the same cycle; x_rdata=pmem_rdata for reads.
  - Commands drop on the next edge and the FSM goes to DONE.
- DONE: one dead cycle with no grant and no command, so the requester can drop its request. The FSM then returns to IDLE. Back-to-back requests from one side are spaced at least 2 cycles after the resp.
- pmem_resp seen in IDLE or DONE is ignored; no client resp is produced.
- pmem_address and pmem_wdata are stable for the whole SERVE state; later changes on client inputs are ignored.
- A requester that drops its request mid-SERVE does not abort the transaction. It completes, and the resp pulse is still issued.
- No timeout: SERVE waits indefinitely for pmem_resp.
- Reset asserted mid-transaction: commands and resps deassert immediately (async), the FSM returns to IDLE and last_grant returns to I. A later pmem_resp is ignored.
- The non-granted side never sees resp=1. Its rdata output is 0.

Test Plan:
1. I-only read: i_read=1, i_address=0x1230, pmem_resp after 3 cycles with rdata=0x...DEAD -> pmem_read=1 on cycle 1, pmem_address=0x1230, i_resp=1 and i_rdata=0x...DEAD in the resp cycle, DONE then IDLE.
2. D write-back: d_write=1, d_address=0x8040, d_wdata=0xA5A5...A5 -> pmem_write=1 with latched wdata; d_resp on pmem_resp; pmem_read stays 0 throughout.
3. Conflict sequence: i_read and d_read both asserted from reset -> first grant D, second grant I, third (both still requesting) D. Each grant is separated by DONE.
4. Input instability: change d_address to 0xFFFE mid-SERVE_D -> pmem_address stays at the granted value 0x8040.
5. Stray and abandoned: pmem_resp pulsed in IDLE -> no client resp. Separately, i_read dropped mid-SERVE_I -> transaction completes and i_resp still pulses.
6. Reset mid-SERVE_D: rst_n=0 for 1 cycle during an outstanding write -> pmem_write=0 immediately, state IDLE, last_grant=I. A next conflict is granted to D.
